// File: rtl/dmio_arbiter_if.sv
// -----------------------------------------------------------------------------
// dmio_arbiter_if
// Bundle of every signal between the two requesters, the arbiter and the
// shared data-memory/IO port.
//   Requester side : req0/1, wr0/1, addr0/1, wdata0/1 (in to the arbiter)
//                    gnt0/1, ack0/1, rdata, busy     (out of the arbiter)
//   Memory side    : mem_address, mem_data_write, mem_wr (out of the arbiter)
//                    mem_data_read                      (in to the arbiter)
// Modports:
//   slave  - the arbiter's view
//   master - the environment's view (requesters plus memory/IO block)
// Address bit ADDR_W-1 selects IO, bits ADDR_W-2:0 select DM.
// -----------------------------------------------------------------------------
interface dmio_arbiter_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 64
);
  logic              req0;
  logic              req1;
  logic              wr0;
  logic              wr1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic              gnt0;
  logic              gnt1;
  logic              ack0;
  logic              ack1;
  logic [DATA_W-1:0] rdata;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_data_write;
  logic              mem_wr;
  logic [DATA_W-1:0] mem_data_read;
  logic              busy;

  modport slave (
    input  req0, req1, wr0, wr1, addr0, addr1, wdata0, wdata1, mem_data_read,
    output gnt0, gnt1, ack0, ack1, rdata, mem_address, mem_data_write, mem_wr, busy
  );

  modport master (
    output req0, req1, wr0, wr1, addr0, addr1, wdata0, wdata1, mem_data_read,
    input  gnt0, gnt1, ack0, ack1, rdata, mem_address, mem_data_write, mem_wr, busy
  );
endinterface

// File: rtl/dmio_arbiter.sv
// -----------------------------------------------------------------------------
// dmio_arbiter
// Two-requester arbiter/sequencer for the shared data-memory/IO port.
// Requester 0 is the load/store stage, requester 1 the program/debug loader.
// Each access takes an ACCESS cycle (port driven, gnt pulse) followed by a
// RESP cycle (ack pulse, registered read data). Arbitration runs in IDLE and
// in RESP, so back-to-back accesses issue every second cycle.
//
// Ports:
//   clk    - clock, all state updates on the rising edge
//   rst_n  - asynchronous active-low reset
//   bus    - dmio_arbiter_if.slave: requester handshakes and memory port
//
// Build option:
//   DMIO_ARB_FIXED_PRIO_EN - when defined, requester 0 always wins a tie
//                            (last_winner is still tracked but not used).
//                            When undefined, ties are resolved round-robin.
// -----------------------------------------------------------------------------
module dmio_arbiter #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  dmio_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_nx_s;

  // Combinational decisions
  logic              any_req_s;
  logic              arb_en_s;
  logic              tie_win_s;
  logic              win_id_s;
  logic              win_wr_s;
  logic [ADDR_W-1:0] win_addr_s;
  logic [DATA_W-1:0] win_wdata_s;
  logic              gnt0_nx_s;
  logic              gnt1_nx_s;
  logic              ack0_nx_s;
  logic              ack1_nx_s;
  logic              mem_wr_nx_s;
  logic              busy_nx_s;
  logic              rdata_ld_s;

  // Latched request of the access in flight
  logic              last_winner_r;
  logic              winner_r;
  logic              wr_r;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] wdata_r;

  // Registered outputs
  logic [DATA_W-1:0] rdata_r;
  logic              gnt0_r;
  logic              gnt1_r;
  logic              ack0_r;
  logic              ack1_r;
  logic              mem_wr_r;
  logic              busy_r;

  // Winner selection: a lone requester always wins; tie_win decides a tie.
  function automatic logic pick_winner(input logic r0, input logic r1, input logic tie_win);
    logic w;
    if (r0 && r1) begin
      w = tie_win;
    end else if (r1) begin
      w = 1'b1;
    end else begin
      w = 1'b0;
    end
    return w;
  endfunction

`ifdef DMIO_ARB_FIXED_PRIO_EN
  // Tie-break: requester 0 always has priority.
  assign tie_win_s = 1'b0;
`else
  // Tie-break: the requester that did not win last time goes first.
  assign tie_win_s = ~last_winner_r;
`endif

  // Next-state, winner mux and next values of the registered outputs.
  always_comb begin
    state_nx_s  = state_r;
    arb_en_s    = 1'b0;
    any_req_s   = bus.req0 | bus.req1;
    win_id_s    = pick_winner(bus.req0, bus.req1, tie_win_s);
    win_wr_s    = 1'b0;
    win_addr_s  = {ADDR_W{1'b0}};
    win_wdata_s = {DATA_W{1'b0}};

    case (state_r)
      ST_IDLE, ST_RESP: begin
        if (any_req_s) begin
          arb_en_s   = 1'b1;
          state_nx_s = ST_ACCESS;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        // Requests seen here are not arbitrated; they are either still
        // held in RESP (and compete then) or have been withdrawn.
        state_nx_s = ST_RESP;
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase

    if (win_id_s) begin
      win_wr_s    = bus.wr1;
      win_addr_s  = bus.addr1;
      win_wdata_s = bus.wdata1;
    end else begin
      win_wr_s    = bus.wr0;
      win_addr_s  = bus.addr0;
      win_wdata_s = bus.wdata0;
    end

    gnt0_nx_s   = arb_en_s & ~win_id_s;
    gnt1_nx_s   = arb_en_s &  win_id_s;
    // The write strobe only ever accompanies the ACCESS cycle of a write.
    mem_wr_nx_s = arb_en_s & win_wr_s;
    ack0_nx_s   = (state_r == ST_ACCESS) & ~winner_r;
    ack1_nx_s   = (state_r == ST_ACCESS) &  winner_r;
    rdata_ld_s  = (state_r == ST_ACCESS) & ~wr_r;
    busy_nx_s   = (state_nx_s != ST_IDLE);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Latch the winning request; the latched address/data drive the port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_winner_r <= 1'b1;
      winner_r      <= 1'b0;
      wr_r          <= 1'b0;
      addr_r        <= {ADDR_W{1'b0}};
      wdata_r       <= {DATA_W{1'b0}};
    end else if (arb_en_s) begin
      last_winner_r <= win_id_s;
      winner_r      <= win_id_s;
      wr_r          <= win_wr_s;
      addr_r        <= win_addr_s;
      wdata_r       <= win_wdata_s;
    end else begin
      last_winner_r <= last_winner_r;
      winner_r      <= winner_r;
      wr_r          <= wr_r;
      addr_r        <= addr_r;
      wdata_r       <= wdata_r;
    end
  end

  // Handshake pulses, write strobe and busy flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt0_r   <= 1'b0;
      gnt1_r   <= 1'b0;
      ack0_r   <= 1'b0;
      ack1_r   <= 1'b0;
      mem_wr_r <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      gnt0_r   <= gnt0_nx_s;
      gnt1_r   <= gnt1_nx_s;
      ack0_r   <= ack0_nx_s;
      ack1_r   <= ack1_nx_s;
      mem_wr_r <= mem_wr_nx_s;
      busy_r   <= busy_nx_s;
    end
  end

  // Read data captured at the end of a read's ACCESS cycle; held otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_r <= {DATA_W{1'b0}};
    end else if (rdata_ld_s) begin
      rdata_r <= bus.mem_data_read;
    end else begin
      rdata_r <= rdata_r;
    end
  end

  assign bus.gnt0           = gnt0_r;
  assign bus.gnt1           = gnt1_r;
  assign bus.ack0           = ack0_r;
  assign bus.ack1           = ack1_r;
  assign bus.rdata          = rdata_r;
  assign bus.mem_address    = addr_r;
  assign bus.mem_data_write = wdata_r;
  assign bus.mem_wr         = mem_wr_r;
  assign bus.busy           = busy_r;

endmodule

// File: doc/dmio_arbiter.md
# dmio_arbiter

Two-requester arbiter and sequencer for the shared data-memory/IO port (13-bit address: bit 12 selects IO, bits 11:0 select DM; 64-bit data). It sits between the datapath's load/store stage (requester 0) and the program/debug loader (requester 1) on one side, and the memory/IO block on the other. It serialises accesses, registers the winning request onto the port, and returns a one-cycle acknowledge carrying registered read data.

## Interface
- ADDR_W, 13, address width; bit ADDR_W-1 is the IO select and is passed through untouched
- DATA_W, 64, data width
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- req0, req1  in  1  access request from requester 0 / 1
- wr0, wr1  in  1  1 = write, 0 = read; valid while reqN=1
- addr0, addr1  in  ADDR_W  access address; valid while reqN=1
- wdata0, wdata1  in  DATA_W  write data; valid while reqN=1 and wrN=1
- gnt0, gnt1  out  1  one-cycle pulse: request accepted and on the port this cycle
- ack0, ack1  out  1  one-cycle pulse: access complete
- rdata  out  DATA_W  read data, valid when ack0 or ack1 is high and the access was a read
- mem_address  out  ADDR_W  port address
- mem_data_write  out  DATA_W  port write data
- mem_wr  out  1  port write strobe
- mem_data_read  in  DATA_W  port read data (combinational from mem_address)
- busy  out  1  high in ACCESS and RESP

## Operation
- States: IDLE, ACCESS, RESP.
- Arbitration in IDLE and RESP: if any reqN=1, pick a winner, latch its wr/addr/wdata and identity into registers, go to ACCESS; else go to / stay in IDLE.
- Round-robin: a last_winner flag; when both request, the requester that did not win last wins. last_winner updates on each win.
- ACCESS: mem_address/mem_data_write come from the latched registers; mem_wr = latched wr; gntN=1 for the winner. At the clock edge ending ACCESS, rdata is loaded from mem_data_read on reads; it holds its previous value on writes. Next state: RESP.
- RESP: ackN=1 for the winner; mem_wr=0; mem_address holds. Arbitration runs (see above).
- Requester rule: hold req/wr/addr/wdata stable until gnt is seen; in the cycle after gnt (the RESP cycle), reqN=1 is treated as a new request.
- A request deasserted before gnt is withdrawn; no access occurs.
- mem_wr is asserted for exactly one cycle per write and never outside ACCESS.

## Timing
- Reset (asynchronous assert, synchronous release): state=IDLE; gnt0/1, ack0/1, mem_wr, busy = 0; mem_address, mem_data_write, rdata = 0; last_winner=1, so requester 0 wins the first tie.
- Latency: req seen at edge E (IDLE) -> gnt and port driven in cycle E+1 -> ack and rdata in cycle E+2.
- Back-to-back throughput: one access per 2 cycles (ACCESS, RESP, ACCESS, ...). From IDLE the first access costs 3 cycles from req to ack.
- Reset asserted during ACCESS aborts the access: mem_wr drops immediately, and no ack is issued.
- Simultaneous req0 and req1 in RESP with one of them the current winner re-requesting: round-robin applies, and the other requester wins.

## Configuration
- DMIO_ARB_FIXED_PRIO_EN defined: requester 0 always wins ties; last_winner is not used for the decision, though it is still reset and updated. Requester 1 can starve under continuous req0.
- Not defined: round-robin as described above.

## Test plan
- Single read: after reset, req0=1, wr0=0, addr0=0x010, mem_data_read=0xDEAD_BEEF_0000_0001 -> gnt0 in cycle 1 with mem_address=0x010, mem_wr=0; ack0 in cycle 2 with rdata=0xDEAD_BEEF_0000_0001.
- Single write to IO: req1=1, wr1=1, addr1=0x1000, wdata1=0xA5 -> mem_wr=1 for exactly one cycle with mem_address=0x1000, mem_data_write=0xA5, then ack1; gnt0 and ack0 stay 0.
- Tie, round-robin: req0 and req1 held high with reads -> grants go 0, 1, 0, 1 on successive ACCESS cycles, one ack every 2 cycles. With DMIO_ARB_FIXED_PRIO_EN defined -> grants go 0, 0, 0, ...
- Withdrawal: req1 pulses high for one cycle while the arbiter is in ACCESS serving requester 0 and drops before RESP -> no gnt1, no ack1, and the arbiter returns to IDLE.
- Reset mid-access: rst_n low in the ACCESS cycle of a write -> mem_wr=0 and busy=0 immediately; after release, no ack, and the next tie is won by requester 0.
